// File: rtl/strassen_pkg.sv
// Shared definitions for the 2x2 Strassen C-combine stage: FSM encoding,
// quadrant addresses and product indices.
package strassen_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SUM     = 2'd1,
        WR0     = 2'd2,
        WR1     = 2'd3
    } c_state_t;

    localparam int unsigned M_COUNT = 7;

    localparam logic [1:0] Q11 = 2'd0;
    localparam logic [1:0] Q12 = 2'd1;
    localparam logic [1:0] Q21 = 2'd2;
    localparam logic [1:0] Q22 = 2'd3;

    localparam logic [2:0] M1_IDX        = 3'd0;
    localparam logic [2:0] M2_IDX        = 3'd1;
    localparam logic [2:0] M3_IDX        = 3'd2;
    localparam logic [2:0] M4_IDX        = 3'd3;
    localparam logic [2:0] M5_IDX        = 3'd4;
    localparam logic [2:0] M6_IDX        = 3'd5;
    localparam logic [2:0] M7_IDX        = 3'd6;
    localparam logic [2:0] M_IDX_ILLEGAL = 3'd7;

    localparam logic [M_COUNT-1:0] MASK_FULL = 7'h7F;

    // One-hot of a product index; the illegal index 7 shifts out to zero.
    function automatic logic [M_COUNT-1:0] idx_onehot(input logic [2:0] idx);
        return 7'(1) << idx;
    endfunction

endpackage

// File: rtl/strassen_c_combine_quad_adder.sv
// c_quad_adder: combinational 4-operand signed add/sub with per-operand sign.
// C_COMBINE_SAT_EN selects saturation to the signed width range instead of wrap.
module c_quad_adder
#(
    parameter int unsigned width = 32
)(
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    input  logic [width-1:0] d,
    input  logic [3:0]       neg,
    output logic [width-1:0] sum
);

`ifdef C_COMBINE_SAT_EN
    localparam int unsigned EW = width + 2;
`else
    localparam int unsigned EW = width;
`endif

    logic signed [EW-1:0] ops [4];
    logic signed [EW-1:0] total;

    // Sign-extend every operand, then accumulate with per-operand add/sub.
    always_comb begin
        ops[0] = EW'(signed'(a));
        ops[1] = EW'(signed'(b));
        ops[2] = EW'(signed'(c));
        ops[3] = EW'(signed'(d));
        total  = '0;
        for (int i = 0; i < 4; i++) begin
            total = neg[i] ? (total - ops[i]) : (total + ops[i]);
        end
    end

`ifdef C_COMBINE_SAT_EN
    localparam logic signed [EW-1:0] SMAX = EW'({1'b0, {(width-1){1'b1}}});
    localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);

    always_comb begin
        if (total > SMAX) begin
            sum = width'(SMAX);
        end else if (total < SMIN) begin
            sum = width'(SMIN);
        end else begin
            sum = width'(total);
        end
    end
`else
    always_comb begin
        sum = total;
    end
`endif

endmodule

// File: rtl/strassen_c_combine.sv
// Collects Strassen products M1..M7 in any order, forms C11..C22 and writes
// them to C storage in two dual-port cycles. C_COMBINE_SAT_EN: saturating sums.
module strassen_c_combine
    import strassen_pkg::*;
#(
    parameter int unsigned width = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [2:0]       m_idx,
    input  logic [width-1:0] m_data,
    output logic             we,
    output logic [1:0]       addr1,
    output logic [1:0]       addr2,
    output logic [width-1:0] dIn1,
    output logic [width-1:0] dIn2,
    output logic             done,
    output logic             err
);

    c_state_t           state;
    logic [M_COUNT-1:0] mask;
    logic [width-1:0]   m_q [M_COUNT];
    logic [width-1:0]   c21_q;
    logic [width-1:0]   c22_q;

    logic               xfer;
    logic [M_COUNT-1:0] hit;
    logic [width-1:0]   s11, s12, s21, s22;

    assign xfer = m_valid && m_ready;
    assign hit  = idx_onehot(m_idx);

    c_quad_adder #(.width(width)) u_c11 (
        .a(m_q[M1_IDX]), .b(m_q[M4_IDX]), .c(m_q[M5_IDX]), .d(m_q[M7_IDX]),
        .neg(4'b0100), .sum(s11)
    );
    c_quad_adder #(.width(width)) u_c12 (
        .a(m_q[M3_IDX]), .b(m_q[M5_IDX]), .c('0), .d('0),
        .neg(4'b0000), .sum(s12)
    );
    c_quad_adder #(.width(width)) u_c21 (
        .a(m_q[M2_IDX]), .b(m_q[M4_IDX]), .c('0), .d('0),
        .neg(4'b0000), .sum(s21)
    );
    c_quad_adder #(.width(width)) u_c22 (
        .a(m_q[M1_IDX]), .b(m_q[M2_IDX]), .c(m_q[M3_IDX]), .d(m_q[M6_IDX]),
        .neg(4'b0010), .sum(s22)
    );

    // FSM with registered write port: C11/C12 go straight into dIn1/dIn2 on
    // entry to WR0, C21/C22 are held in registers for WR1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            mask    <= '0;
            for (int i = 0; i < M_COUNT; i++) begin
                m_q[i] <= '0;
            end
            c21_q   <= '0;
            c22_q   <= '0;
            m_ready <= 1'b1;
            we      <= 1'b0;
            addr1   <= '0;
            addr2   <= '0;
            dIn1    <= '0;
            dIn2    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        mask <= mask | hit;
                        for (int i = 0; i < M_COUNT; i++) begin
                            if (hit[i]) begin
                                m_q[i] <= m_data;
                            end
                        end
                        if (m_idx == M_IDX_ILLEGAL || (mask & hit) != '0) begin
                            err <= 1'b1;
                        end
                        if ((mask | hit) == MASK_FULL) begin
                            state   <= SUM;
                            m_ready <= 1'b0;
                        end
                    end
                end
                SUM: begin
                    c21_q <= s21;
                    c22_q <= s22;
                    we    <= 1'b1;
                    addr1 <= Q11;
                    dIn1  <= s11;
                    addr2 <= Q12;
                    dIn2  <= s12;
                    state <= WR0;
                end
                WR0: begin
                    we    <= 1'b1;
                    addr1 <= Q21;
                    dIn1  <= c21_q;
                    addr2 <= Q22;
                    dIn2  <= c22_q;
                    state <= WR1;
                end
                WR1: begin
                    we      <= 1'b0;
                    addr1   <= '0;
                    dIn1    <= '0;
                    addr2   <= '0;
                    dIn2    <= '0;
                    mask    <= '0;
                    m_ready <= 1'b1;
                    done    <= 1'b1;
                    state   <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strassen_c_combine.sv
// Self-checking bench for strassen_c_combine against a behavioural model of
// the C-quadrant formulas (wrap or saturate per C_COMBINE_SAT_EN).
module tb_strassen_c_combine;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  m_idx;
    logic [31:0] m_data;
    logic        we;
    logic [1:0]  addr1, addr2;
    logic [31:0] dIn1, dIn2;
    logic        done, err;

    logic        m8_valid;
    logic        m8_ready;
    logic [2:0]  m8_idx;
    logic [7:0]  m8_data;
    logic        we8;
    logic [1:0]  a8_1, a8_2;
    logic [7:0]  d8_1, d8_2;
    logic        done8, err8;

    int     checks = 0;
    int     errors = 0;
    longint exp_m [7];
    logic   exp_err = 1'b0;

    always #5 clk = ~clk;

    strassen_c_combine #(.width(32)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
        .m_idx(m_idx), .m_data(m_data), .we(we), .addr1(addr1), .addr2(addr2),
        .dIn1(dIn1), .dIn2(dIn2), .done(done), .err(err)
    );

    strassen_c_combine #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .m_valid(m8_valid), .m_ready(m8_ready),
        .m_idx(m8_idx), .m_data(m8_data), .we(we8), .addr1(a8_1), .addr2(a8_2),
        .dIn1(d8_1), .dIn2(d8_2), .done(done8), .err(err8)
    );

    // Reduce an exact sum into a w-bit signed result (wrap or saturate).
    function automatic longint fit(input longint v, input int w);
        longint one, lo, hi, m, r;
        one = 1;
        hi  = (one << (w - 1)) - 1;
        lo  = -(one << (w - 1));
        m   = one << w;
        r   = v;
`ifdef C_COMBINE_SAT_EN
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = v % m;
        if (r > hi) r = r - m;
        if (r < lo) r = r + m;
`endif
        return r;
    endfunction

    function automatic longint quad(input int q);
        case (q)
            0:       return fit(exp_m[0] + exp_m[3] - exp_m[4] + exp_m[6], 32);
            1:       return fit(exp_m[2] + exp_m[4], 32);
            2:       return fit(exp_m[1] + exp_m[3], 32);
            default: return fit(exp_m[0] - exp_m[1] + exp_m[2] + exp_m[5], 32);
        endcase
    endfunction

    // Present one product and wait (bounded) until it is accepted.
    task automatic put(input logic [2:0] idx, input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clk);
        m_valid = 1'b1;
        m_idx   = idx;
        m_data  = d;
        while (!m_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL put_timeout idx=%0d m_ready=%b required 1", idx, m_ready);
        end
        @(posedge clk);
        #1 m_valid = 1'b0;
    endtask

    task automatic send_order(input int order [7], input bit gaps);
        for (int k = 0; k < 7; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            put(3'(order[k]), 32'(exp_m[order[k]]));
        end
    endtask

    // Called just after the edge that accepted the batch's 7th product.
    task automatic check_batch(input string tag);
        logic [31:0] e11, e12, e21, e22;
        e11 = 32'(quad(0));
        e12 = 32'(quad(1));
        e21 = 32'(quad(2));
        e22 = 32'(quad(3));
        @(negedge clk);
        checks++;
        if (we !== 1'b0 || m_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_sum we=%b m_ready=%b done=%b required 0 0 0", tag, we, m_ready, done);
        end
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || addr1 !== 2'd0 || addr2 !== 2'd1 || dIn1 !== e11 || dIn2 !== e12) begin
            errors++;
            $display("FAIL %s_wr0 we=%b a1=%0d d1=%0d a2=%0d d2=%0d required 1 0 %0d 1 %0d",
                     tag, we, addr1, $signed(dIn1), addr2, $signed(dIn2), $signed(e11), $signed(e12));
        end
        @(negedge clk);
        checks++;
        if (we !== 1'b1 || addr1 !== 2'd2 || addr2 !== 2'd3 || dIn1 !== e21 || dIn2 !== e22) begin
            errors++;
            $display("FAIL %s_wr1 we=%b a1=%0d d1=%0d a2=%0d d2=%0d required 1 2 %0d 3 %0d",
                     tag, we, addr1, $signed(dIn1), addr2, $signed(dIn2), $signed(e21), $signed(e22));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || we !== 1'b0 || m_ready !== 1'b1 || dIn1 !== 32'd0 || addr2 !== 2'd0) begin
            errors++;
            $display("FAIL %s_done done=%b we=%b m_ready=%b d1=%0d a2=%0d required 1 0 1 0 0",
                     tag, done, we, m_ready, dIn1, addr2);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s_err err=%b required %b", tag, err, exp_err);
        end
    endtask

    task automatic load_plan1();
        exp_m[0] = 65;  exp_m[1] = 35; exp_m[2] = -2; exp_m[3] = 8;
        exp_m[4] = 24;  exp_m[5] = 22; exp_m[6] = -30;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_valid = 1'b0; m_idx = '0; m_data = '0;
        m8_valid = 1'b0; m8_idx = '0; m8_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (m_ready !== 1'b1 || we !== 1'b0 || addr1 !== 2'd0 || addr2 !== 2'd0 ||
            dIn1 !== 32'd0 || dIn2 !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values rdy=%b we=%b a1=%0d a2=%0d d1=%0d d2=%0d done=%b err=%b required 1 0 0 0 0 0 0 0",
                     m_ready, we, addr1, addr2, dIn1, dIn2, done, err);
        end
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_in_order();
        int order [7] = '{0, 1, 2, 3, 4, 5, 6};
        load_plan1();
        send_order(order, 1'b0);
        check_batch("in_order");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL in_order_done_pulse done=%b required 0", done);
        end
    endtask

    task automatic test_reverse_gaps();
        int order [7] = '{6, 5, 4, 3, 2, 1, 0};
        load_plan1();
        send_order(order, 1'b1);
        check_batch("reverse");
    endtask

    task automatic test_errors();
        int order [7] = '{0, 1, 2, 3, 4, 5, 6};
        load_plan1();
        put(3'd0, 32'd99);
        put(3'd7, 32'd1234);
        exp_err = 1'b1;
        send_order(order, 1'b0);
        check_batch("dup_illegal");
    endtask

    task automatic test_hold_valid();
        int order [7] = '{0, 1, 2, 3, 4, 5, 6};
        load_plan1();
        send_order(order, 1'b0);
        @(negedge clk);
        m_valid = 1'b1; m_idx = 3'd3; m_data = 32'd7;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (m_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready_low cycle=%0d m_ready=%b required 0", c, m_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (m_ready !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL hold_done_accept m_ready=%b done=%b required 1 1", m_ready, done);
        end
        @(posedge clk);
        #1 m_valid = 1'b0;
        exp_m[3] = 7;
        for (int k = 0; k < 7; k++) begin
            if (k != 3) begin
                exp_m[k] = longint'(k * 11 - 20);
                put(3'(k), 32'(exp_m[k]));
            end
        end
        check_batch("hold_next");
    endtask

    task automatic test_reset_mid();
        int order [7] = '{2, 0, 6, 1, 5, 3, 4};
        load_plan1();
        send_order(order, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wr0 we=%b required 1", we);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (we !== 1'b0 || done !== 1'b0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async we=%b done=%b m_ready=%b required 0 0 1", we, done, m_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (err !== 1'b0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_release err=%b m_ready=%b required 0 1", err, m_ready);
        end
        put(3'd4, 32'd5);
        @(negedge clk);
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_mask_empty m_ready=%b required 1", m_ready);
        end
        for (int k = 0; k < 7; k++) exp_m[k] = longint'(3 * k + 1);
        exp_m[4] = 5;
        for (int k = 0; k < 7; k++) if (k != 4) put(3'(k), 32'(exp_m[k]));
        check_batch("rst_fresh");
    endtask

    task automatic test_width8();
        logic [7:0] e11;
`ifdef C_COMBINE_SAT_EN
        e11 = 8'd127;
`else
        e11 = 8'hC8;
`endif
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (m8_ready !== 1'b1) begin
                errors++;
                $display("FAIL w8_ready k=%0d m_ready=%b required 1", k, m8_ready);
            end
            m8_valid = 1'b1;
            m8_idx   = 3'(k);
            m8_data  = (k == 0 || k == 3) ? 8'd100 : 8'd0;
            @(posedge clk);
            #1 m8_valid = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (we8 !== 1'b1 || a8_1 !== 2'd0 || d8_1 !== e11 || a8_2 !== 2'd1 || d8_2 !== 8'd0) begin
            errors++;
            $display("FAIL w8_wr0 we=%b a1=%0d d1=%0d a2=%0d d2=%0d required 1 0 %0d 1 0",
                     we8, a8_1, $signed(d8_1), a8_2, $signed(d8_2), $signed(e11));
        end
        @(negedge clk);
        checks++;
        if (we8 !== 1'b1 || d8_1 !== 8'd100 || d8_2 !== 8'd100 || a8_1 !== 2'd2 || a8_2 !== 2'd3) begin
            errors++;
            $display("FAIL w8_wr1 we=%b d1=%0d d2=%0d required 1 100 100", we8, d8_1, d8_2);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b1 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_done done=%b err=%b required 1 0", done8, err8);
        end
    endtask

    task automatic test_random();
        int order [7];
        int j, tmp;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 7; k++) begin
                order[k] = k;
                exp_m[k] = longint'($signed(32'($urandom)));
            end
            for (int k = 6; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = order[k]; order[k] = order[j]; order[j] = tmp;
            end
            if ($urandom_range(0, 2) == 0) begin
                put(3'(order[0]), $urandom);
                exp_err = 1'b1;
            end
            send_order(order, 1'b1);
            check_batch("random");
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_reverse_gaps();
        test_errors();
        test_hold_valid();
        test_reset_mid();
        test_width8();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/strassen_c_combine.md
Name: strassen_c_combine

Overview:
Upstream feeder of the C-quadrant storage stage in the 2x2 Strassen datapath.
- Collects the seven Strassen products M1..M7 from the multiplier stage via a valid/ready stream, in any order.
- Forms the four C quadrants and writes them into C storage as two dual-port write cycles, two quadrants per cycle.
- One batch equals one 2x2 result.

Parameters:
width, 32, bit width of each product, each quadrant and each write data word (two's complement)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
m_valid  input  1  product on m_idx/m_data is valid
m_ready  output  1  block can accept a product this cycle
m_idx  input  3  product index, 0..6 = M1..M7; 7 is illegal
m_data  input  width  product value, signed
we  output  1  write enable to C storage
addr1  output  2  quadrant address for dIn1
addr2  output  2  quadrant address for dIn2
dIn1  output  width  quadrant data, port 1
dIn2  output  width  quadrant data, port 2
done  output  1  one-cycle pulse after the second write cycle
err  output  1  sticky: illegal index or duplicate product seen

Behaviour:
Reset values (async, immediate):
- state=COLLECT, received mask=0, all M and C registers=0.
- m_ready=1, we=0, addr1=addr2=0, dIn1=dIn2=0, done=0, err=0.

FSM states: COLLECT, SUM, WR0, WR1.

COLLECT:
- m_ready=1.
- A transfer occurs when m_valid && m_ready.
- On a transfer with m_idx<7: store m_data into M[m_idx] and set mask[m_idx].
- If mask[m_idx] was already set: overwrite the value and set err.
- On m_idx==7: no store, set err.
- When the transfer completes the mask (7'h7F), the next state is SUM.

SUM:
- m_ready=0.
- Registers, all modulo 2^width:
  - C11=M1+M4-M5+M7
  - C12=M3+M5
  - C21=M2+M4
  - C22=M1-M2+M3+M6
- Next state is WR0.

WR0:
- we=1, addr1=0, dIn1=C11, addr2=1, dIn2=C12.
- Next state is WR1.

WR1:
- we=1, addr1=2, dIn1=C21, addr2=3, dIn2=C22.
- Next state is COLLECT; clear mask; done=1 for exactly the next cycle, registered.

Outputs and latency:
- we/addr/dIn are decoded from the state register and C registers; the decode is glitch-free relative to clk.
- In states other than WR0/WR1, we=0 and addr/dIn are held at 0.
- Latency: last product accepted at edge N -> WR0 in cycle N+2 -> WR1 in N+3 -> done in N+4.
- Throughput: m_ready is low for 3 cycles per batch; the next batch's first product can be accepted in the done cycle.

Error handling:
- err is cleared only by rst.
- err does not block batch completion.

Reset mid-operation:
- Aborts the batch with no partial write: we drops asynchronously and the mask clears.

Optional Feature:
Macro: C_COMBINE_SAT_EN
- Defined: each quadrant sum is computed at width+2 bits, then saturated to the signed width range (max 2^(width-1)-1, min -2^(width-1)).
- Not defined: plain modulo 2^width wrap-around.
- Latency is identical in both cases.

Decomposition:
Shared package (strassen_pkg) holds:
- FSM state encoding
- quadrant address constants Q11=0, Q12=1, Q21=2, Q22=3
- product index constants M1_IDX..M7_IDX

Sub-module: one natural sub-module, c_quad_adder, a combinational 4-operand signed add/sub with per-operand sign control and the optional saturation. It is instantiated four times, with unused operands tied to 0.

Test Plan:
1. A=[[1,2],[3,4]], B=[[5,6],[7,8]]: send M1..M7 = 65,35,-2,8,24,22,-30 in order -> WR0: (0,19),(1,22); WR1: (2,43),(3,50); done pulses once; err=0.
2. Same products in reverse order with m_valid gaps -> identical writes and latency counted from the 7th accept.
3. Send M1 twice (first 99, then 65), plus the rest; also send idx 7 -> err=1; writes use 65 (C11=19); err stays 1 into the next batch.
4. width=8, M1=100, M4=100, others 0 -> C11=200 wraps to -56; with C_COMBINE_SAT_EN, C11=127.
5. Assert rst during WR0 -> we=0 immediately; after release m_ready=1 and mask empty; a fresh full batch writes correctly.
6. Hold m_valid during SUM/WR0/WR1 -> no transfer (m_ready=0); the product is accepted in the done cycle and counts toward the next batch.
